dma_block_mover: RTL and testbench
==================================

// Module: dma_block_mover
// PURPOSE
//  Executes block-transfer instructions (mem<->IO, mem->mem) the processor hands off once it drops
//  off the data bus. Consumes the 26-bit instruction word and the processor's grant. Drives the
//  shared 8-bit address space: mem 0-191, IO1 192-223, IO2 224-255. Moves count 32-bit words.
//  Each word takes a read cycle then a write cycle.
// PARAMETERS
//  DATA_W   32   bus word width
//  ADDR_W   8    address width (source/destination fields)
//  CNT_W    6    word-count width
// PORTS
//  clock        in   1       single clock; all logic on posedge
//  reset        in   1       synchronous, active-high
//  start        in   1       1-cycle strobe: latch instruction
//  instruction  in   26      op[25:24] type[23:22] src[21:14] dst[13:6] count[5:0]
//  grant        in   1       processor releases bus when 1
//  bus_req      out  1       request bus ownership
//  addr         out  ADDR_W  transfer address
//  memread/memwrite, IORead1/IOWrite1, IORead2/IOWrite2  out 1 each  region strobes
//  data_in      in   DATA_W  bus read data, sampled at end of read cycle
//  data_out     out  DATA_W  bus write data
//  data_oe      out  1       drive data_out onto bus
//  busy/done/error  out 1 each  active / 1-cycle complete / 1-cycle reject
//  remaining    out  CNT_W   words not yet written
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0; addr, data_out and remaining are 0.
//  - Accepted ops: op in {00,01} with type 01 (exactly one of src/dst in IO, other in mem) or
//    type 10 (both in mem). Anything else, or a block where addr+count-1 leaves its start region:
//    error=1 the cycle after start, no bus activity, stay IDLE.
//  - count==0: done=1 the cycle after start, no bus_req.
//  - start while busy: ignored, no side effects.
//  - FSM: IDLE -start ok-> REQ (bus_req=1) -grant-> RD -> WR -> (remaining>0 ? RD : FIN) -> IDLE.
//  - RD: addr=src_ptr; the read strobe for src region is 1; data_in goes to hold reg at the next edge.
//  - WR: addr=dst_ptr, data_out=hold, data_oe=1; the write strobe for dst region is 1.
//    Both pointers +1 and remaining -1 at the end of WR.
//  - Exactly one strobe is high in RD/WR; all are 0 in other states. No X on any output.
//  - Latency: 2 cycles per word after grant. done pulses in FIN, 2*count+1 cycles after grant seen.
//  - grant falls: a word in progress (RD or WR) completes its WR. The FSM then returns to REQ and
//    holds pointers and remaining. It resumes RD on grant. grant is never checked inside a word.
//  - Overlapping mem->mem copies run in ascending order; with dst>src, data propagates (defined).
//  - busy=1 in REQ/RD/WR/FIN. bus_req=1 in REQ/RD/WR.
//  - Reset mid-transfer: abort, IDLE next cycle, no done pulse.
// CONFIGURATION
//  DMA_BLOCK_CHECKSUM_EN defined: adds output checksum[DATA_W-1:0]. It is the modulo-2^32 sum of
//  words written, cleared on accepted start and valid while done=1.
//  Undefined: no checksum port, no adder.
// STRUCTURE
//  dma_pkg: op/type codes, region bounds (MEM_HI=191, IO1_LO=192, IO1_HI=223, IO2_LO=224),
//  FSM state enum.
//  Sub-module dma_addr_decode: combinational addr -> region {MEM,IO1,IO2}. Instantiated for src,
//  dst and the end-of-block checks.
// TESTING
//  1 mem->IO1: op=01 type=01 src=10 dst=200 cnt=4, grant=1 -> 4 RD/WR pairs;
//    addr 10,200,11,201..; IOWrite1 on WR; done 9 cycles after grant.
//  2 IO2->mem: op=00 type=01 src=230 dst=0 cnt=3 -> IORead2 then memwrite;
//    mem[0..2]=IO2[230..232]; remaining 3->0.
//  3 Reject: src=190 cnt=5 type=10 (crosses 191) -> error 1 cycle, no strobes.
//    Also op=10 (add) -> error.
//  4 Pause: cnt=6, drop grant during 2nd RD -> that word's WR completes; bus_req stays 1.
//    Restore grant after 5 cycles -> resumes at word 3; total 6 writes.
//  5 Reset in WR of word 2 -> next cycle all strobes 0, busy 0, no done.
//    Then cnt=0 start -> done next cycle.
//  6 (DMA_BLOCK_CHECKSUM_EN) words 1,2,0xFFFFFFFF -> checksum=2 at done.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the block-transfer DMA: opcode/type encodings, address map bounds,
// bus region and controller state enums.
package dma_pkg;

    localparam logic [1:0] OP_XFER0     = 2'b00;
    localparam logic [1:0] OP_XFER1     = 2'b01;
    localparam logic [1:0] TYPE_MEM_IO  = 2'b01;
    localparam logic [1:0] TYPE_MEM_MEM = 2'b10;

    localparam int unsigned MEM_HI = 191;
    localparam int unsigned IO1_LO = 192;
    localparam int unsigned IO1_HI = 223;
    localparam int unsigned IO2_LO = 224;

    typedef enum logic [1:0] {RegMem, RegIo1, RegIo2} region_e;

    typedef enum logic [2:0] {StIdle, StReq, StRd, StWr, StFin} state_e;

    function automatic logic is_io(region_e r);
        return r != RegMem;
    endfunction

endpackage

// File: rtl/dma_addr_decode.sv
// Combinational address-map decode: classifies a bus address as memory, IO1 or IO2.
module dma_addr_decode
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] addr,
    output region_e           region
);

    always_comb begin
        region = RegIo2;
        if (addr <= ADDR_W'(MEM_HI)) begin
            region = RegMem;
        end else if (addr >= ADDR_W'(IO1_LO) && addr <= ADDR_W'(IO1_HI)) begin
            region = RegIo1;
        end else if (addr >= ADDR_W'(IO2_LO)) begin
            region = RegIo2;
        end
    end

endmodule

// File: rtl/dma_block_mover.sv
// Block-transfer DMA engine: validates an instruction, then copies count words src->dst as
// read/write bus-cycle pairs while granted. Optional DMA_BLOCK_CHECKSUM_EN adds a write-sum output.
module dma_block_mover
    import dma_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [2*ADDR_W+CNT_W+3:0] instruction,
    input  logic                      grant,
    output logic                      bus_req,
    output logic [ADDR_W-1:0]         addr,
    output logic                      memread,
    output logic                      memwrite,
    output logic                      IORead1,
    output logic                      IOWrite1,
    output logic                      IORead2,
    output logic                      IOWrite2,
    input  logic [DATA_W-1:0]         data_in,
    output logic [DATA_W-1:0]         data_out,
    output logic                      data_oe,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
`ifdef DMA_BLOCK_CHECKSUM_EN
    output logic [CNT_W-1:0]          remaining,
    output logic [DATA_W-1:0]         checksum
`else
    output logic [CNT_W-1:0]          remaining
`endif
);

    logic [1:0]        op, typ;
    logic [ADDR_W-1:0] src, dst;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W:0]   src_end, dst_end;
    region_e           src_region, dst_region, src_end_region, dst_end_region;
    logic              op_ok, type_ok, span_ok, accept_ok;

    assign cnt = instruction[CNT_W-1:0];
    assign dst = instruction[CNT_W +: ADDR_W];
    assign src = instruction[CNT_W+ADDR_W +: ADDR_W];
    assign typ = instruction[CNT_W+2*ADDR_W +: 2];
    assign op  = instruction[CNT_W+2*ADDR_W+2 +: 2];

    // Extra top bit catches blocks that run past the end of the address space.
    assign src_end = {1'b0, src} + (ADDR_W+1)'(cnt) - (ADDR_W+1)'(1);
    assign dst_end = {1'b0, dst} + (ADDR_W+1)'(cnt) - (ADDR_W+1)'(1);

    dma_addr_decode #(.ADDR_W(ADDR_W)) u_dec_src (.addr(src), .region(src_region));
    dma_addr_decode #(.ADDR_W(ADDR_W)) u_dec_dst (.addr(dst), .region(dst_region));
    dma_addr_decode #(.ADDR_W(ADDR_W)) u_dec_src_end (
        .addr  (src_end[ADDR_W-1:0]),
        .region(src_end_region)
    );
    dma_addr_decode #(.ADDR_W(ADDR_W)) u_dec_dst_end (
        .addr  (dst_end[ADDR_W-1:0]),
        .region(dst_end_region)
    );

    assign op_ok   = (op == OP_XFER0) || (op == OP_XFER1);
    assign type_ok = ((typ == TYPE_MEM_IO) && (is_io(src_region) != is_io(dst_region))) ||
                     ((typ == TYPE_MEM_MEM) && (src_region == RegMem) && (dst_region == RegMem));
    assign span_ok = (cnt == '0) ||
                     (!src_end[ADDR_W] && !dst_end[ADDR_W] &&
                      (src_end_region == src_region) && (dst_end_region == dst_region));
    assign accept_ok = op_ok && type_ok && span_ok;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
    region_e           src_reg_q, src_reg_d, dst_reg_q, dst_reg_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              error_q, error_d, zdone_q, zdone_d;
`ifdef DMA_BLOCK_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        src_reg_d   = src_reg_q;
        dst_reg_d   = dst_reg_q;
        remaining_d = remaining_q;
        hold_d      = hold_q;
        error_d     = 1'b0;
        zdone_d     = 1'b0;
`ifdef DMA_BLOCK_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (!accept_ok) begin
                        error_d = 1'b1;
                    end else begin
                        src_ptr_d   = src;
                        dst_ptr_d   = dst;
                        src_reg_d   = src_region;
                        dst_reg_d   = dst_region;
                        remaining_d = cnt;
`ifdef DMA_BLOCK_CHECKSUM_EN
                        sum_d       = '0;
`endif
                        if (cnt == '0) zdone_d = 1'b1;
                        else           state_d = StReq;
                    end
                end
            end
            StReq: if (grant) state_d = StRd;
            StRd: begin
                hold_d  = data_in;
                state_d = StWr;
            end
            StWr: begin
                src_ptr_d   = src_ptr_q + ADDR_W'(1);
                dst_ptr_d   = dst_ptr_q + ADDR_W'(1);
                remaining_d = remaining_q - CNT_W'(1);
`ifdef DMA_BLOCK_CHECKSUM_EN
                sum_d       = sum_q + hold_q;
`endif
                // Grant is only sampled between words, so a started word always finishes.
                if (remaining_q == CNT_W'(1)) state_d = StFin;
                else if (grant)               state_d = StRd;
                else                          state_d = StReq;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            src_reg_q   <= RegMem;
            dst_reg_q   <= RegMem;
            remaining_q <= '0;
            hold_q      <= '0;
            error_q     <= 1'b0;
            zdone_q     <= 1'b0;
`ifdef DMA_BLOCK_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            src_reg_q   <= src_reg_d;
            dst_reg_q   <= dst_reg_d;
            remaining_q <= remaining_d;
            hold_q      <= hold_d;
            error_q     <= error_d;
            zdone_q     <= zdone_d;
`ifdef DMA_BLOCK_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    always_comb begin
        addr     = '0;
        data_out = '0;
        data_oe  = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        IORead1  = 1'b0;
        IOWrite1 = 1'b0;
        IORead2  = 1'b0;
        IOWrite2 = 1'b0;
        case (state_q)
            StRd: begin
                addr = src_ptr_q;
                case (src_reg_q)
                    RegMem:  memread = 1'b1;
                    RegIo1:  IORead1 = 1'b1;
                    default: IORead2 = 1'b1;
                endcase
            end
            StWr: begin
                addr     = dst_ptr_q;
                data_out = hold_q;
                data_oe  = 1'b1;
                case (dst_reg_q)
                    RegMem:  memwrite = 1'b1;
                    RegIo1:  IOWrite1 = 1'b1;
                    default: IOWrite2 = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    assign bus_req   = (state_q == StReq) || (state_q == StRd) || (state_q == StWr);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StFin) || zdone_q;
    assign error     = error_q;
    assign remaining = remaining_q;
`ifdef DMA_BLOCK_CHECKSUM_EN
    assign checksum  = sum_q;
`endif

endmodule

// File: tb/tb_dma_block_mover.sv
// Bench for dma_block_mover: table of instructions plus hand sequences, with a bus-cycle scoreboard.
module tb_dma_block_mover;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [25:0] instruction = '0;
    logic        grant = 1'b1;
    logic        bus_req, memread, memwrite, IORead1, IOWrite1, IORead2, IOWrite2;
    logic [7:0]  addr;
    logic [31:0] data_in, data_out;
    logic        data_oe, busy, done, error;
    logic [5:0]  remaining;
`ifdef DMA_BLOCK_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    dma_block_mover dut (
        .clock(clock), .reset(reset), .start(start), .instruction(instruction), .grant(grant),
        .bus_req(bus_req), .addr(addr), .memread(memread), .memwrite(memwrite),
        .IORead1(IORead1), .IOWrite1(IOWrite1), .IORead2(IORead2), .IOWrite2(IOWrite2),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .busy(busy), .done(done),
`ifdef DMA_BLOCK_CHECKSUM_EN
        .error(error), .remaining(remaining), .checksum(checksum)
`else
        .error(error), .remaining(remaining)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int rd_seen = 0;
    int wr_seen = 0;

    logic [31:0] bus_mem [256];
    logic [31:0] shadow  [256];

    typedef struct {
        logic [7:0]  addr;
        logic [5:0]  stb;
        logic [31:0] data;
        logic        is_wr;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [1:0] op;
        logic [1:0] typ;
        logic [7:0] src;
        logic [7:0] dst;
        logic [5:0] cnt;
        logic       err;
    } vec_t;
    vec_t vecs[16];

    assign data_in = bus_mem[addr];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    // Strobe vector order: memread, memwrite, IORead1, IOWrite1, IORead2, IOWrite2
    function automatic logic [5:0] rd_stb(input logic [7:0] a);
        if (a < 8'd192) return 6'b100000;
        if (a < 8'd224) return 6'b001000;
        return 6'b000010;
    endfunction

    function automatic logic [5:0] wr_stb(input logic [7:0] a);
        if (a < 8'd192) return 6'b010000;
        if (a < 8'd224) return 6'b000100;
        return 6'b000001;
    endfunction

    task automatic reinit();
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = init_word(i);
            shadow[i]  = init_word(i);
        end
    endtask

    task automatic set_word(input int a, input logic [31:0] v);
        bus_mem[a] = v;
        shadow[a]  = v;
    endtask

    task automatic push_transfer(input logic [7:0] src, input logic [7:0] dst, input int cnt);
        exp_t e;
        logic [7:0] s, d;
        for (int i = 0; i < cnt; i++) begin
            s = src + 8'(i);
            d = dst + 8'(i);
            e.addr = s; e.stb = rd_stb(src); e.data = '0; e.is_wr = 1'b0;
            exp_q.push_back(e);
            e.addr = d; e.stb = wr_stb(dst); e.data = shadow[s]; e.is_wr = 1'b1;
            exp_q.push_back(e);
            shadow[d] = shadow[s];
        end
    endtask

    task automatic issue(input logic [25:0] ins);
        @(posedge clock); #1;
        instruction = ins;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output logic ok);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clock); #1;
            n++;
            if (done) ok = 1'b1;
        end
    endtask

    // Bus memory model: writes land at the clock edge ending the write cycle.
    always @(posedge clock) begin
        if (memwrite || IOWrite1 || IOWrite2) bus_mem[addr] = data_out;
    end

    // Scoreboard: every strobed bus cycle must match the next expected transaction.
    always @(negedge clock) begin
        logic [5:0] stb;
        exp_t e;
        stb = {memread, memwrite, IORead1, IOWrite1, IORead2, IOWrite2};
        if (stb != 6'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bus_cycle: strobes %b addr %0d expected none", stb, addr);
            end else begin
                e = exp_q.pop_front();
                check("strobe", 32'(stb), 32'(e.stb));
                check("addr", 32'(addr), 32'(e.addr));
                check("data_oe", 32'(data_oe), 32'(e.is_wr));
                if (e.is_wr) begin
                    check("wdata", data_out, e.data);
                    wr_seen++;
                end else begin
                    rd_seen++;
                end
            end
        end
    end

    initial begin
        int   n;
        logic ok;
        int   base;
        logic found;
        reinit();

        vecs[0]  = '{2'b00, 2'b01, 8'd230, 8'd0,   6'd3,  1'b0};
        vecs[1]  = '{2'b01, 2'b01, 8'd10,  8'd200, 6'd4,  1'b0};
        vecs[2]  = '{2'b00, 2'b10, 8'd190, 8'd0,   6'd5,  1'b1};
        vecs[3]  = '{2'b10, 2'b10, 8'd0,   8'd50,  6'd2,  1'b1};
        vecs[4]  = '{2'b11, 2'b01, 8'd10,  8'd200, 6'd2,  1'b1};
        vecs[5]  = '{2'b00, 2'b00, 8'd10,  8'd20,  6'd2,  1'b1};
        vecs[6]  = '{2'b00, 2'b11, 8'd10,  8'd20,  6'd2,  1'b1};
        vecs[7]  = '{2'b00, 2'b01, 8'd10,  8'd20,  6'd2,  1'b1};
        vecs[8]  = '{2'b00, 2'b01, 8'd200, 8'd230, 6'd2,  1'b1};
        vecs[9]  = '{2'b00, 2'b10, 8'd10,  8'd200, 6'd2,  1'b1};
        vecs[10] = '{2'b01, 2'b01, 8'd220, 8'd0,   6'd5,  1'b1};
        vecs[11] = '{2'b00, 2'b01, 8'd5,   8'd250, 6'd10, 1'b1};
        vecs[12] = '{2'b01, 2'b10, 8'd0,   8'd188, 6'd4,  1'b0};
        vecs[13] = '{2'b00, 2'b01, 8'd5,   8'd252, 6'd4,  1'b0};
        vecs[14] = '{2'b00, 2'b10, 8'd20,  8'd21,  6'd4,  1'b0};
        vecs[15] = '{2'b01, 2'b10, 8'd0,   8'd0,   6'd0,  1'b0};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset_ctrl", {28'b0, busy, done, error, bus_req}, 32'h0);
        check("reset_strobes", {26'b0, memread, memwrite, IORead1, IOWrite1, IORead2, IOWrite2},
              32'h0);
        check("reset_addr", 32'(addr), 32'h0);
        check("reset_data", data_out, 32'h0);
        check("reset_oe_rem", {25'b0, data_oe, remaining}, 32'h0);
        reset = 1'b0;

        // Table: accept/reject decisions, boundaries, overlap, zero count
        for (int v = 0; v < 16; v++) begin
            logic xfer;
            xfer = !vecs[v].err && (vecs[v].cnt != 0);
            if (xfer) push_transfer(vecs[v].src, vecs[v].dst, int'(vecs[v].cnt));
            issue({vecs[v].op, vecs[v].typ, vecs[v].src, vecs[v].dst, vecs[v].cnt});
            check($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].err));
            check($sformatf("v%0d_zdone", v), 32'(done), 32'(!vecs[v].err && vecs[v].cnt == 0));
            check($sformatf("v%0d_bus_req", v), 32'(bus_req), 32'(xfer));
            check($sformatf("v%0d_busy", v), 32'(busy), 32'(xfer));
            check($sformatf("v%0d_remaining", v), 32'(remaining),
                  vecs[v].err ? 32'h0 : 32'(vecs[v].cnt));
            if (xfer) begin
                wait_done(n, ok);
                check($sformatf("v%0d_done_seen", v), 32'(ok), 32'h1);
                check($sformatf("v%0d_latency", v), 32'(n), 32'(2 * int'(vecs[v].cnt) + 1));
                check($sformatf("v%0d_drained", v), 32'(exp_q.size()), 32'h0);
                check($sformatf("v%0d_rem_end", v), 32'(remaining), 32'h0);
            end
            @(posedge clock); #1;
            check($sformatf("v%0d_pulse_end", v), {30'b0, error, done}, 32'h0);
        end
        for (int i = 0; i < 3; i++)
            check($sformatf("io2_copy_%0d", i), bus_mem[i], init_word(230 + i));

        // Latency from a late grant: mem->IO1, 4 words, done 9 cycles after grant seen
        grant = 1'b0;
        push_transfer(8'd10, 8'd200, 4);
        issue({2'b01, 2'b01, 8'd10, 8'd200, 6'd4});
        @(posedge clock); #1;
        check("late_grant_req", {30'b0, bus_req, busy}, 32'h3);
        grant = 1'b1;
        wait_done(n, ok);
        check("late_grant_done_seen", 32'(ok), 32'h1);
        check("late_grant_latency", 32'(n), 32'd9);
        check("late_grant_drained", 32'(exp_q.size()), 32'h0);

        // Pause: grant drops during the 2nd read, word completes, then resumes at word 3
        base = rd_seen;
        push_transfer(8'd100, 8'd150, 6);
        issue({2'b00, 2'b10, 8'd100, 8'd150, 6'd6});
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clock); #1;
            if (rd_seen == base + 2) found = 1'b1;
        end
        check("pause_reached_rd2", 32'(found), 32'h1);
        base = wr_seen - 1;
        grant = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        check("pause_word2_written", 32'(wr_seen - base), 32'd2);
        check("pause_bus_req_held", {30'b0, bus_req, busy}, 32'h3);
        check("pause_remaining", 32'(remaining), 32'd4);
        issue({2'b01, 2'b10, 8'd0, 8'd0, 6'd0});
        check("busy_start_ignored", {30'b0, done, error}, 32'h0);
        check("busy_start_rem", 32'(remaining), 32'd4);
        repeat (2) @(posedge clock);
        #1;
        grant = 1'b1;
        wait_done(n, ok);
        check("pause_done_seen", 32'(ok), 32'h1);
        check("pause_total_writes", 32'(wr_seen - base), 32'd6);
        check("pause_drained", 32'(exp_q.size()), 32'h0);

        // Reset during the write of word 2: abort with no done
        reinit();
        base = wr_seen;
        push_transfer(8'd30, 8'd80, 5);
        issue({2'b00, 2'b10, 8'd30, 8'd80, 6'd5});
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clock); #1;
            if (wr_seen == base + 2) found = 1'b1;
        end
        check("abort_reached_wr2", 32'(found), 32'h1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_strobes", {26'b0, memread, memwrite, IORead1, IOWrite1, IORead2, IOWrite2},
              32'h0);
        check("abort_ctrl", {29'b0, busy, done, bus_req}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("abort_no_done", {30'b0, done, busy}, 32'h0);
        end
        exp_q.delete();
        reinit();
        issue({2'b00, 2'b10, 8'd5, 8'd6, 6'd0});
        check("zero_after_abort_done", {29'b0, done, busy, bus_req}, 32'h4);
        @(posedge clock); #1;
        check("zero_after_abort_pulse", 32'(done), 32'h0);

`ifdef DMA_BLOCK_CHECKSUM_EN
        set_word(40, 32'h1);
        set_word(41, 32'h2);
        set_word(42, 32'hFFFF_FFFF);
        push_transfer(8'd40, 8'd60, 3);
        issue({2'b00, 2'b10, 8'd40, 8'd60, 6'd3});
        wait_done(n, ok);
        check("csum_done_seen", 32'(ok), 32'h1);
        check("checksum", checksum, 32'h2);
        check("csum_drained", 32'(exp_q.size()), 32'h0);
`endif

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
